// File: rtl/multi_drv_resolver.sv
// multi_drv_resolver: resolves NCH driven channels into one W-bit beat (wired-AND/OR/priority)
// behind a 2-entry valid/ready buffer. Define RESOLVER_PARITY_EN to add the out_par port.

module multi_drv_resolver_lane #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] data,
  input  logic [W-1:0] ref_data,
  output logic [W-1:0] and_term,
  output logic [W-1:0] or_term,
  output logic         diff
);
  // Disabled lanes are identity elements for the AND/OR reductions
  assign and_term = en ? data : '1;
  assign or_term  = en ? data : '0;
  assign diff     = en && (data != ref_data);
endmodule

module multi_drv_resolver #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH-1:0]     drv_en,
  input  logic [NCH*W-1:0]   drv_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               out_conflict,
  output logic               out_none,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   conflict_cnt
`ifdef RESOLVER_PARITY_EN
  ,
  output logic               out_par
`endif
);

  if (NCH < 2 || MODE > 2) begin : g_bad_cfg
    $fatal(1, "multi_drv_resolver: requires NCH >= 2 and MODE <= 2");
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic         conflict;
    logic         none;
`ifdef RESOLVER_PARITY_EN
    logic         par;
`endif
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [W-1:0]            first;
  logic [NCH-1:0][W-1:0]   and_t, or_t;
  logic [NCH-1:0]          diff;
  logic [W-1:0]            and_all, or_all;
  beat_t                   res, head, tail;
  state_t                  state, nxt;
  logic                    acc, dlv;
  logic [CNT_W-1:0]        cnt;

  // Lowest enabled channel: priority result and the reference for contention
  always_comb begin
    first = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (drv_en[i]) first = drv_data[i*W +: W];
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    multi_drv_resolver_lane #(.W(W)) u_lane (
      .en       (drv_en[g]),
      .data     (drv_data[g*W +: W]),
      .ref_data (first),
      .and_term (and_t[g]),
      .or_term  (or_t[g]),
      .diff     (diff[g])
    );
  end

  always_comb begin
    and_all = '1;
    or_all  = '0;
    for (int i = 0; i < NCH; i++) begin
      and_all &= and_t[i];
      or_all  |= or_t[i];
    end
  end

  always_comb begin
    res          = '0;
    res.none     = ~|drv_en;
    res.conflict = |diff;
    if (!res.none) begin
      if (MODE == 0)      res.data = and_all;
      else if (MODE == 1) res.data = or_all;
      else                res.data = first;
    end
`ifdef RESOLVER_PARITY_EN
    res.par = ^res.data;
`endif
  end

  assign acc = in_valid && in_ready;
  assign dlv = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      EMPTY:   if (acc) nxt = ONE;
      ONE:     if (acc && !dlv) nxt = TWO;
               else if (dlv && !acc) nxt = EMPTY;
      TWO:     if (dlv) nxt = ONE;
      default: nxt = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
  end

  // head always holds the oldest beat; tail only matters in TWO
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (acc) head <= res;
        ONE:   if (acc && dlv) head <= res;
               else if (acc)   tail <= res;
        TWO:   if (dlv) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      cnt <= '0;
    else if (acc && res.conflict && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

  assign out_data     = head.data;
  assign out_conflict = head.conflict;
  assign out_none     = head.none;
  assign conflict_cnt = cnt;
`ifdef RESOLVER_PARITY_EN
  assign out_par      = head.par;
`endif

endmodule
